// File: rtl/timer_pkg.sv
// timer_pkg: shared types and constants for the countdown timer.
//   state_e  - two-state countdown FSM encoding (StIdle, StRun)
//   SegTable - 16-entry active-low 7-segment table, {a,b,c,d,e,f,g} at bits [6:0]
package timer_pkg;

    localparam int unsigned CountW = 4;
    localparam int unsigned SegW   = 7;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    // Index is the hex digit; a lit segment is 0.
    localparam logic [SegW-1:0] SegTable [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage

// File: rtl/timer_if.sv
// timer_if: bundles the timer's control inputs and display/expiry outputs.
//   Start_Timer    - load/start request
//   Value          - countdown length in seconds
//   OneHz          - asynchronous 1 Hz tick input
//   Expired        - one-clock completion pulse
//   Anode_Activate - active-low digit enable
//   LED_out        - active-low segments {a..g}
// master drives the controls (testbench / parent); slave is the timer.
interface timer_if;
    import timer_pkg::*;

    logic              Start_Timer;
    logic [CountW-1:0] Value;
    logic              OneHz;
    logic              Expired;
    logic              Anode_Activate;
    logic [SegW-1:0]   LED_out;

    modport master (
        output Start_Timer, Value, OneHz,
        input  Expired, Anode_Activate, LED_out
    );

    modport slave (
        input  Start_Timer, Value, OneHz,
        output Expired, Anode_Activate, LED_out
    );

endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational hex-to-7-segment decode, active-low outputs.
//   digit - 4-bit value to display
//   seg   - segments {a,b,c,d,e,f,g} at bits [6:0], 0 = lit
module seg7_decoder
    import timer_pkg::*;
(
    input  logic [CountW-1:0] digit,
    output logic [SegW-1:0]   seg
);

    assign seg = SegTable[digit];

endmodule

// File: rtl/timer.sv
// timer: single-digit countdown timer driven by an asynchronous 1 Hz tick.
//   clk        - system clock, rising edge
//   Sync_Reset - asynchronous active-low reset (name is historical)
//   bus        - timer_if.slave: Start_Timer/Value/OneHz in, Expired/Anode_Activate/LED_out out
// OneHz is synchronised, edge-detected into a one-clock tick, and each tick
// decrements the count while running. Expired is a registered one-clock pulse
// issued on the edge the count reaches (or is found at) zero.
module timer
    import timer_pkg::*;
(
    input logic    clk,
    input logic    Sync_Reset,
    timer_if.slave bus
);

    logic              sync1_q, sync2_q, sync3_q;
    logic [1:0]        vld_q;
    logic              armed_q;
    logic              tick_q;
    state_e            state_q, state_d;
    logic [CountW-1:0] count_q, count_d;
    logic              expired_q, expired_d;

    // Synchroniser and registered edge detector. vld_q marks when sync2_q holds
    // a real sample rather than its reset value; armed_q only sets once a real
    // low level has been seen, so OneHz already high at reset release cannot
    // masquerade as a rising edge.
    always_ff @(posedge clk or negedge Sync_Reset) begin
        if (!Sync_Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            vld_q   <= 2'b00;
            armed_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= bus.OneHz;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            vld_q   <= {vld_q[0], 1'b1};
            if (vld_q[1] && !sync2_q) begin
                armed_q <= 1'b1;
            end
            tick_q  <= armed_q & sync2_q & ~sync3_q;
        end
    end

    always_ff @(posedge clk or negedge Sync_Reset) begin
        if (!Sync_Reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        expired_d = 1'b0;
        if (bus.Start_Timer) begin
            // Start overrides everything, including a coincident tick.
            count_d = bus.Value;
            state_d = StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (count_q == '0) begin
                        // Zero-length countdown expires without a tick.
                        expired_d = 1'b1;
                        state_d   = StIdle;
                    end else if (tick_q) begin
                        count_d = count_q - 4'd1;
                        if (count_q == 4'd1) begin
                            expired_d = 1'b1;
                            state_d   = StIdle;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    seg7_decoder u_seg7_decoder (
        .digit (count_q),
        .seg   (bus.LED_out)
    );

    assign bus.Expired        = expired_q;
    assign bus.Anode_Activate = 1'b0;

endmodule

// File: tb/tb_timer.sv
// tb_timer: table-driven self-checking bench for timer. Each vector is held
// for one clock; its expected display/expiry is pushed to a scoreboard when
// driven and popped and compared 1 ns after the following rising edge.
// Reset behaviour is exercised by hand-written sequences.
module tb_timer;

    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct {
        logic       start;
        logic [3:0] value;
        logic       hz;
        logic [3:0] cnt;
        logic       exp;
    } vec_t;

    typedef struct {
        logic [6:0] led;
        logic       exp;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    vec_t vecs [$];
    exp_t sb   [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    timer_if bus ();

    timer dut (
        .clk        (clk),
        .Sync_Reset (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic add(input int n, input logic s, input logic [3:0] v, input logic h,
                       input logic [3:0] c, input logic e);
        vec_t t;
        t.start = s;
        t.value = v;
        t.hz    = h;
        t.cnt   = c;
        t.exp   = e;
        for (int i = 0; i < n; i++) vecs.push_back(t);
    endtask

    // Called 1 ns after a rising edge; leaves the same phase on return.
    task automatic run_vecs(input string tag);
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            bus.Start_Timer = vecs[i].start;
            bus.Value       = vecs[i].value;
            bus.OneHz       = vecs[i].hz;
            e.led = SEG[vecs[i].cnt];
            e.exp = vecs[i].exp;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("%s[%0d] LED_out", tag, i), {25'd0, bus.LED_out}, {25'd0, e.led});
            check($sformatf("%s[%0d] Expired", tag, i), {31'd0, bus.Expired}, {31'd0, e.exp});
            check($sformatf("%s[%0d] Anode", tag, i), {31'd0, bus.Anode_Activate}, 32'd0);
        end
        vecs.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " LED_out"}, {25'd0, bus.LED_out}, {25'd0, 7'b0000001});
        check({tag, " Expired"}, {31'd0, bus.Expired}, 32'd0);
        check({tag, " Anode"}, {31'd0, bus.Anode_Activate}, 32'd0);
    endtask

    initial begin
        bus.Start_Timer = 1'b1;
        bus.Value       = 4'd7;
        bus.OneHz       = 1'b0;

        // Held in reset with activity on every input: outputs stay at reset values.
        for (int i = 0; i < 8; i++) begin
            bus.OneHz = (i % 2 == 1);
            @(posedge clk);
            #1;
            check_reset_outputs($sformatf("in_reset[%0d]", i));
        end

        bus.Start_Timer = 1'b0;
        bus.Value       = 4'd0;
        bus.OneHz       = 1'b0;
        rst_n           = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("post_release");

        // Value=3 countdown, then two ticks while idle.
        add(1, 1, 3, 0, 3, 0); add(1, 0, 0, 0, 3, 0);
        add(3, 0, 0, 1, 3, 0); add(1, 0, 0, 1, 2, 0); add(3, 0, 0, 0, 2, 0);
        add(3, 0, 0, 1, 2, 0); add(1, 0, 0, 1, 1, 0); add(3, 0, 0, 0, 1, 0);
        add(3, 0, 0, 1, 1, 0); add(1, 0, 0, 1, 0, 1); add(3, 0, 0, 0, 0, 0);
        add(4, 0, 0, 1, 0, 0); add(3, 0, 0, 0, 0, 0);
        add(4, 0, 0, 1, 0, 0); add(3, 0, 0, 0, 0, 0);
        // Value=9, two ticks, restart with Value=2 and let it expire.
        add(1, 1, 9, 0, 9, 0); add(1, 0, 0, 0, 9, 0);
        add(3, 0, 0, 1, 9, 0); add(1, 0, 0, 1, 8, 0); add(3, 0, 0, 0, 8, 0);
        add(3, 0, 0, 1, 8, 0); add(1, 0, 0, 1, 7, 0); add(1, 0, 0, 0, 7, 0);
        add(1, 1, 2, 0, 2, 0); add(1, 0, 0, 0, 2, 0);
        add(3, 0, 0, 1, 2, 0); add(1, 0, 0, 1, 1, 0); add(3, 0, 0, 0, 1, 0);
        add(3, 0, 0, 1, 1, 0); add(1, 0, 0, 1, 0, 1); add(3, 0, 0, 0, 0, 0);
        // Start held high across a tick: tick is lost, Value keeps reloading.
        add(1, 1, 4, 0, 4, 0); add(4, 1, 4, 1, 4, 0); add(1, 0, 0, 1, 4, 0);
        add(1, 1, 5, 1, 5, 0); add(3, 0, 0, 0, 5, 0);
        // Value=0 restart over a running count: expires with no tick.
        add(1, 1, 0, 0, 0, 0); add(1, 0, 0, 0, 0, 1); add(1, 0, 0, 0, 0, 0);
        add(4, 0, 0, 1, 0, 0); add(3, 0, 0, 0, 0, 0);
        run_vecs("main");

        // Value=5, one tick, then reset mid-countdown with OneHz held high.
        add(1, 1, 5, 0, 5, 0); add(1, 0, 0, 0, 5, 0);
        add(3, 0, 0, 1, 5, 0); add(1, 0, 0, 1, 4, 0);
        run_vecs("pre_abort");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset_outputs($sformatf("abort_hold[%0d]", i));
        end
        rst_n = 1'b1;

        // OneHz still high at release must not tick; the next real edge must.
        add(1, 1, 5, 1, 5, 0); add(8, 0, 0, 1, 5, 0); add(3, 0, 0, 0, 5, 0);
        add(3, 0, 0, 1, 5, 0); add(1, 0, 0, 1, 4, 0); add(3, 0, 0, 0, 4, 0);
        run_vecs("post_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and Sync_Reset as the codebase names them.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 Sync_Reset  input  1  asynchronous active-low reset, despite its historical name.
REQ-004 Start_Timer  input  1  synchronous load/start request, level-sampled on each clk edge.
REQ-005 Value  input  4  countdown length in seconds (0-15), sampled when Start_Timer=1.
REQ-006 OneHz  input  1  asynchronous 1 Hz tick; each rising edge is one elapsed second.
REQ-007 Expired  output  1  single-clk pulse marking countdown completion.
REQ-008 Anode_Activate  output  1  active-low digit-enable for the single 7-segment digit.
REQ-009 LED_out  output  7  active-low segments {a,b,c,d,e,f,g} at bits [6:0], showing the remaining count.

Function
REQ-010 The block SHALL hold a 4-bit count register and a two-state FSM: IDLE and RUN.
REQ-011 OneHz SHALL pass through a 2-flop synchronizer, then a registered rising-edge detector producing a 1-clk tick.
- The tick SHALL assert on the 3rd clk edge after OneHz is first sampled high.
- One tick SHALL be produced per OneHz rising edge.
REQ-012 When Start_Timer=1 in any state, on that clk edge:
- count SHALL load Value and the FSM SHALL enter RUN;
- any tick in the same cycle SHALL be ignored;
- Expired SHALL be 0 in that cycle.
REQ-013 Holding Start_Timer high SHALL keep reloading Value, so counting begins only after Start_Timer returns to 0.
REQ-014 In RUN with a tick and count>1, count SHALL decrement by 1.
REQ-015 In RUN with a tick and count=1:
- count SHALL become 0;
- Expired SHALL pulse high for exactly one clk cycle;
- the FSM SHALL enter IDLE.
REQ-016 In RUN with count=0 (Value=0 loaded), Expired SHALL pulse on the first clk edge after Start_Timer deasserts, and the FSM SHALL enter IDLE without waiting for a tick.
REQ-017 In IDLE, ticks SHALL be ignored; count SHALL hold and Expired SHALL stay 0.
REQ-018 Count SHALL never wrap below 0.
REQ-019 LED_out SHALL be a combinational hex decode of count, active-low:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111;
- 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-020 Anode_Activate SHALL be constant 0 (digit always enabled) when out of reset.

Reset
REQ-021 While Sync_Reset=0, asynchronously:
- count=0 and FSM=IDLE;
- synchronizer and edge flops cleared;
- Expired=0, Anode_Activate=0, LED_out=0000001.
REQ-022 Reset asserted mid-countdown SHALL abort it immediately with no Expired pulse.
REQ-023 After release, the first tick SHALL require a fresh OneHz 0->1 transition.
- OneHz already high at release SHALL NOT generate a tick.

Structure
REQ-024 The FSM state encoding and the 16-entry segment table SHALL be defined in a shared package timer_pkg.
REQ-025 The 7-segment decoder SHALL be a separate sub-module seg7_decoder (4-bit in, 7-bit active-low out).
- The synchronizer, edge detector, counter and FSM SHALL reside in timer.

Verification
REQ-026 Reset held low, OneHz toggling -> Expired=0, LED_out=0000001, Anode_Activate=0 throughout.
REQ-027 Value=3 with Start_Timer pulsed, then three OneHz rising edges:
- LED_out steps 0000110 -> 0010010 -> 1001111 -> 0000001;
- Expired pulses once, one clk wide, 3 clks after the third edge.
REQ-028 A 4th and 5th OneHz edge after expiry -> count stays 0 and no further Expired pulse.
REQ-029 Value=9 start, two ticks (count=7), then Start_Timer with Value=2 -> LED_out=0010010 on the next clk, and expiry after 2 more ticks.
REQ-030 Value=0 start -> Expired pulses on the clk after Start_Timer deasserts, with no OneHz edge needed.
REQ-031 Value=5 start, one tick, then reset pulse -> count=0 and no Expired pulse.
- OneHz high at release produces no tick.
